// File: rtl/bip_control.sv
// BIP control unit: owns the PC, runs a FETCH/EXEC sequence per instruction,
// and decodes each instruction into datapath and data-memory controls.
module bip_control #(
  parameter int PC_WIDTH    = 11,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [15:0]            Instr,
  output logic [PC_WIDTH-1:0]    PC_Addr,
  output logic [PC_WIDTH-1:0]    Data,
  output logic [1:0]             SetA,
  output logic                   SetB,
  output logic                   WrAcc,
  output logic                   Op,
  output logic                   WrRam,
  output logic                   RdRam,
  output logic                   Busy,
  output logic                   Halted,
  output logic [COUNT_WIDTH-1:0] Clk_Count
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  typedef struct packed {
    logic [1:0] set_a;
    logic       set_b;
    logic       wr_acc;
    logic       op;
    logic       wr_ram;
    logic       rd_ram;
  } ctrl_t;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] A_MEM = 2'b00;
  localparam logic [1:0] A_IMM = 2'b01;
  localparam logic [1:0] A_ALU = 2'b10;

  state_t                state, state_nxt;
  logic [PC_WIDTH-1:0]   pc, pc_nxt;
  logic [COUNT_WIDTH-1:0] cnt;
  ctrl_t                 ctrl;
  logic [PC_WIDTH-1:0]   data_c;

  logic [4:0]            opcode;
  logic [PC_WIDTH-1:0]   operand;

  assign opcode  = Instr[15:11];
  assign operand = PC_WIDTH'(Instr[10:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Next state, PC update and EXEC-gated decode in one combinational process.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ctrl      = '0;
    data_c    = '0;
    case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: state_nxt = EXEC;
      EXEC: begin
        data_c = operand;
        if (opcode == OP_HLT) begin
          state_nxt = HALT;
        end else begin
          state_nxt = FETCH;
          pc_nxt    = pc + PC_WIDTH'(1);
        end
        case (opcode)
          OP_STO:  ctrl.wr_ram = 1'b1;
          OP_LD: begin
            ctrl.rd_ram = 1'b1;
            ctrl.set_a  = A_MEM;
            ctrl.wr_acc = 1'b1;
          end
          OP_LDI: begin
            ctrl.set_a  = A_IMM;
            ctrl.wr_acc = 1'b1;
          end
          OP_ADD: begin
            ctrl.rd_ram = 1'b1;
            ctrl.set_a  = A_ALU;
            ctrl.op     = 1'b1;
            ctrl.wr_acc = 1'b1;
          end
          OP_ADDI: begin
            ctrl.set_a  = A_ALU;
            ctrl.set_b  = 1'b1;
            ctrl.op     = 1'b1;
            ctrl.wr_acc = 1'b1;
          end
          OP_SUB: begin
            ctrl.rd_ram = 1'b1;
            ctrl.set_a  = A_ALU;
            ctrl.wr_acc = 1'b1;
          end
          OP_SUBI: begin
            ctrl.set_a  = A_ALU;
            ctrl.set_b  = 1'b1;
            ctrl.wr_acc = 1'b1;
          end
          default: ctrl = '0;
        endcase
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Cycle counter saturates instead of wrapping so long runs stay monotonic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if ((state == FETCH || state == EXEC) && cnt != '1)
      cnt <= cnt + COUNT_WIDTH'(1);
  end

  assign PC_Addr   = pc;
  assign Data      = data_c;
  assign SetA      = ctrl.set_a;
  assign SetB      = ctrl.set_b;
  assign WrAcc     = ctrl.wr_acc;
  assign Op        = ctrl.op;
  assign WrRam     = ctrl.wr_ram;
  assign RdRam     = ctrl.rd_ram;
  assign Busy      = (state == FETCH) || (state == EXEC);
  assign Halted    = (state == HALT);
  assign Clk_Count = cnt;

endmodule

// File: tb/tb_bip_control.sv
// Scoreboarded bench for bip_control: directed programs push expected EXEC
// decodes; a negedge monitor pops and compares during each EXEC cycle.
module tb_bip_control;
  localparam int PW = 11;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   Instr = '0;
  logic [PW-1:0] PC_Addr, Data;
  logic [1:0]    SetA;
  logic          SetB, WrAcc, Op, WrRam, RdRam, Busy, Halted;
  logic [CW-1:0] Clk_Count;

  bip_control #(.PC_WIDTH(PW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .Instr(Instr),
    .PC_Addr(PC_Addr), .Data(Data), .SetA(SetA), .SetB(SetB),
    .WrAcc(WrAcc), .Op(Op), .WrRam(WrRam), .RdRam(RdRam),
    .Busy(Busy), .Halted(Halted), .Clk_Count(Clk_Count)
  );

  always #5 clk = ~clk;

  // Program memory: Instr registered one cycle after PC_Addr.
  logic [15:0] mem [0:2047];
  always @(posedge clk) Instr <= mem[PC_Addr];

  typedef struct packed {
    logic [1:0]  seta;
    logic        setb, wracc, op, wrram, rdram;
    logic [10:0] data;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t mon_x;
  bit   phase = 1'b0;

  function automatic exp_t e(input logic [1:0] a, input logic b, input logic w,
                             input logic o, input logic wr, input logic rd,
                             input logic [10:0] d);
    return {a, b, w, o, wr, rd, d};
  endfunction

  function automatic exp_t act();
    return {SetA, SetB, WrAcc, Op, WrRam, RdRam, Data};
  endfunction

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, a, x, $time);
    end
  endtask

  // Monitor: bench-side phase tracks FETCH/EXEC alternation while Busy.
  always @(negedge clk) begin
    if (!Busy) phase = 1'b0;
    else if (!phase) begin
      chk("fetch_strobes", act(), 0);
      phase = 1'b1;
    end else begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL exec_unexpected: got decode %0h with no expected entry", act());
      end else begin
        mon_x = q.pop_front();
        chk("exec_decode", act(), mon_x);
      end
      chk("rd_wr_exclusive", {31'd0, RdRam & WrRam}, 0);
      chk("wracc_wr_exclusive", {31'd0, WrAcc & WrRam}, 0);
      phase = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    tick(3);
    reset = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!Halted && n < budget) begin
      tick(1);
      n++;
    end
    chk("halt_reached", {31'd0, Halted}, 1);
  endtask

  task automatic clear_mem(input logic [15:0] w);
    for (int i = 0; i < 2048; i++) mem[i] = w;
  endtask

  task automatic load_prog1();
    clear_mem(16'h0000);
    mem[0] = 16'h1805; mem[1] = 16'h2803; mem[2] = 16'h080A; mem[3] = 16'h0000;
    q.push_back(e(2'b01, 0, 1, 0, 0, 0, 11'd5));
    q.push_back(e(2'b10, 1, 1, 1, 0, 0, 11'd3));
    q.push_back(e(2'b00, 0, 0, 0, 1, 0, 11'd10));
    q.push_back(e(2'b00, 0, 0, 0, 0, 0, 11'd0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mem(16'h0000);
    // 1: reset state, then idle with start=0
    #1;
    chk("rst_async_busy", {31'd0, Busy}, 0);
    chk("rst_async_pc", PC_Addr, 0);
    tick(3);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("idle_pc", PC_Addr, 0);
      chk("idle_busy", {30'd0, Busy, Halted}, 0);
      chk("idle_strobes", act(), 0);
      chk("idle_count", Clk_Count, 0);
    end

    // 2: LDI/ADDI/STO/HLT, then start is ignored in HALT
    load_prog1();
    pulse_start();
    wait_halt(50);
    chk("p1_queue_drained", q.size(), 0);
    chk("p1_pc", PC_Addr, 3);
    chk("p1_count", Clk_Count, 8);
    chk("p1_busy", {31'd0, Busy}, 0);
    pulse_start();
    tick(2);
    pulse_start();
    tick(4);
    chk("halt_sticky", {30'd0, Busy, Halted}, 1);
    chk("halt_count", Clk_Count, 8);
    chk("halt_pc", PC_Addr, 3);
    chk("halt_strobes", act(), 0);

    // 3: LD/ADD/SUB/HLT
    do_reset();
    clear_mem(16'h0000);
    mem[0] = 16'h1004; mem[1] = 16'h2005; mem[2] = 16'h3006;
    q.push_back(e(2'b00, 0, 1, 0, 0, 1, 11'd4));
    q.push_back(e(2'b10, 0, 1, 1, 0, 1, 11'd5));
    q.push_back(e(2'b10, 0, 1, 0, 0, 1, 11'd6));
    q.push_back(e(2'b00, 0, 0, 0, 0, 0, 11'd0));
    pulse_start();
    wait_halt(50);
    chk("p2_queue_drained", q.size(), 0);
    chk("p2_pc", PC_Addr, 3);
    chk("p2_count", Clk_Count, 8);

    // 4: undefined opcodes act as NOP with Data=operand
    do_reset();
    clear_mem(16'h0000);
    mem[0] = 16'hF800; mem[1] = 16'h5007;
    q.push_back(e(2'b00, 0, 0, 0, 0, 0, 11'd0));
    q.push_back(e(2'b00, 0, 0, 0, 0, 0, 11'd7));
    q.push_back(e(2'b00, 0, 0, 0, 0, 0, 11'd0));
    pulse_start();
    tick(2);
    chk("nop_pc_adv", PC_Addr, 1);
    wait_halt(50);
    chk("p3_pc", PC_Addr, 2);
    chk("p3_count", Clk_Count, 6);

    // 5: 2048 NOPs, PC wraps to 0 while staying busy
    do_reset();
    clear_mem(16'h4000);
    for (int i = 0; i < 2048; i++) q.push_back(e(2'b00, 0, 0, 0, 0, 0, 11'd0));
    pulse_start();
    tick(4094);
    chk("wrap_pc_last", PC_Addr, 2047);
    chk("wrap_count_pre", Clk_Count, 4094);
    tick(2);
    chk("wrap_pc", PC_Addr, 0);
    chk("wrap_busy", {31'd0, Busy}, 1);
    chk("wrap_count", Clk_Count, 4096);
    chk("wrap_queue_drained", q.size(), 0);
    reset = 1'b0;
    #1;
    chk("wrap_rst_busy", {31'd0, Busy}, 0);
    chk("wrap_rst_count", Clk_Count, 0);

    // 6: asynchronous reset during ADDI EXEC
    do_reset();
    clear_mem(16'h0000);
    mem[0] = 16'h1805; mem[1] = 16'h2803; mem[2] = 16'h080A;
    q.push_back(e(2'b01, 0, 1, 0, 0, 0, 11'd5));
    pulse_start();
    tick(3);
    chk("addi_exec_live", act(), e(2'b10, 1, 1, 1, 0, 0, 11'd3));
    #1 reset = 1'b0;
    #1;
    chk("async_wracc", {31'd0, WrAcc}, 0);
    chk("async_strobes", act(), 0);
    chk("async_pc", PC_Addr, 0);
    chk("async_busy", {31'd0, Busy}, 0);
    tick(1);
    reset = 1'b1;
    tick(3);
    chk("post_rst_idle", {30'd0, Busy, Halted}, 0);
    chk("post_rst_pc", PC_Addr, 0);
    chk("post_rst_queue", q.size(), 0);
    load_prog1();
    pulse_start();
    wait_halt(50);
    chk("rerun_pc", PC_Addr, 3);
    chk("rerun_queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
